// File: rtl/mem_port_arbiter.sv
// Arbitrates one backing memory port between instruction fetch and data access.
// Data has priority, but a bounded streak counter guarantees that a waiting fetch still progresses.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic              i_flush_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    logic [1:0] state;
    logic [3:0] streak;
    logic       squash;
    logic       owner_d;
    logic       i_ready_r;
    logic       grant_d;
    logic       grant_i;

    assign grant_d = d_req_i && (!i_req_i || (streak < MAX_S));
    assign grant_i = !grant_d && i_req_i && !i_flush_i;

    // A flush arriving in the completion cycle must still hide the fetched instruction.
    assign i_ready_o = i_ready_r & ~(i_flush_i & ~owner_d);
    assign stall_o   = (i_req_i & ~i_ready_o) | (d_req_i & ~d_ready_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            streak      <= '0;
            squash      <= 1'b0;
            owner_d     <= 1'b0;
            i_ready_r   <= 1'b0;
            d_ready_o   <= 1'b0;
            i_rdata_o   <= '0;
            d_rdata_o   <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            i_ready_r <= 1'b0;
            d_ready_o <= 1'b0;

            if ((state == IDLE || state == DONE) && mem_ack_i)
                err_o <= 1'b1;
            if ((state == BUSY_I && !i_req_i) || (state == BUSY_D && !d_req_i))
                err_o <= 1'b1;

            // A data requester that backs off forfeits its accumulated streak.
            if (!d_req_i && i_req_i)
                streak <= '0;

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d     <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_we_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        state       <= BUSY_D;
                        if (i_req_i)
                            streak <= streak + 4'd1;
                    end else if (grant_i) begin
                        owner_d    <= 1'b0;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= i_addr_i;
                        state      <= BUSY_I;
                        streak     <= '0;
                    end
                end
                BUSY_I: begin
                    if (i_flush_i)
                        squash <= 1'b1;
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!squash && !i_flush_i) begin
                            i_rdata_o <= mem_rdata_i;
                            i_ready_r <= 1'b1;
                        end
                        squash <= 1'b0;
                        state  <= DONE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        d_rdata_o <= mem_rdata_i;
                        d_ready_o <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for starvation, flush and completion-cycle flush.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .i_req_i    (i_req),
        .i_addr_i   (i_addr),
        .i_flush_i  (i_flush),
        .i_rdata_o  (i_rdata),
        .i_ready_o  (i_ready),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_rdata_o  (d_rdata),
        .d_ready_o  (d_ready),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_ack_i  (mem_ack),
        .mem_rdata_i(mem_rdata),
        .stall_o    (stall),
        .err_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        i_flush;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_i_ready;
        logic        e_d_ready;
        logic [31:0] e_i_rdata;
        logic [31:0] e_d_rdata;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;
    localparam int NVEC = 20;

    vec_t vecs [NVEC];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst       = v.rst;
        i_req     = v.i_req;
        i_addr    = v.i_addr;
        i_flush   = v.i_flush;
        d_req     = v.d_req;
        d_we      = v.d_we;
        d_addr    = v.d_addr;
        d_wdata   = v.d_wdata;
        mem_ack   = v.ack;
        mem_rdata = v.rdata;
    endtask

    task automatic idle_inputs();
        rst = 0; i_req = 0; i_addr = '0; i_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // Called at a negedge; completes one fetch with an immediate ack.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bit found = 0;
        i_req  = 1;
        i_addr = addr;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (mem_req) found = 1;
        end
        check_output({tag, " grant timeout"}, 32'(found), 32'd1);
        check_output({tag, " mem_addr"}, mem_addr, addr);
        check_output({tag, " mem_we"}, 32'(mem_we), 32'd0);
        mem_ack   = 1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack = 0;
        #1;
        check_output({tag, " i_ready"}, 32'(i_ready), 32'd1);
        check_output({tag, " i_rdata"}, i_rdata, data);
        i_req = 0;
    endtask

    initial begin
        bit owners [6];
        bit exp_order [6];
        int ngrants;
        bit found;

        //                rst i_req i_addr  fl d_req we d_addr   d_wdata ack rdata          | mreq mwe maddr   mwdata  ir dr i_rdata        d_rdata        stall err
        vecs[0]  = '{N, N, 32'h0, N, Y, N, 32'h10, 32'h0, N, 32'h0,          N, N, 32'h0,  32'h0, N, N, 32'h0,        32'h0,        Y, N};
        vecs[1]  = '{N, N, 32'h0, N, Y, N, 32'h10, 32'h0, N, 32'h0,          Y, N, 32'h10, 32'h0, N, N, 32'h0,        32'h0,        Y, N};
        vecs[2]  = '{N, N, 32'h0, N, Y, N, 32'h10, 32'h0, N, 32'h0,          Y, N, 32'h10, 32'h0, N, N, 32'h0,        32'h0,        Y, N};
        vecs[3]  = '{N, N, 32'h0, N, Y, N, 32'h10, 32'h0, Y, 32'hDEADBEEF,   Y, N, 32'h10, 32'h0, N, N, 32'h0,        32'h0,        Y, N};
        vecs[4]  = '{N, N, 32'h0, N, Y, N, 32'h10, 32'h0, N, 32'h0,          N, N, 32'h10, 32'h0, N, Y, 32'h0,        32'hDEADBEEF, N, N};
        vecs[5]  = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, N, 32'h10, 32'h0, N, N, 32'h0,        32'hDEADBEEF, N, N};
        vecs[6]  = '{N, Y, 32'h0, N, Y, Y, 32'h20, 32'h5, N, 32'h0,          N, N, 32'h10, 32'h0, N, N, 32'h0,        32'hDEADBEEF, Y, N};
        vecs[7]  = '{N, Y, 32'h0, N, Y, Y, 32'h20, 32'h5, Y, 32'h11111111,   Y, Y, 32'h20, 32'h5, N, N, 32'h0,        32'hDEADBEEF, Y, N};
        vecs[8]  = '{N, Y, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, Y, 32'h20, 32'h5, N, Y, 32'h0,        32'h11111111, Y, N};
        vecs[9]  = '{N, Y, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, Y, 32'h20, 32'h5, N, N, 32'h0,        32'h11111111, Y, N};
        vecs[10] = '{N, Y, 32'h0, N, N, N, 32'h0,  32'h0, Y, 32'h00A00093,   Y, N, 32'h0,  32'h5, N, N, 32'h0,        32'h11111111, Y, N};
        vecs[11] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, N, 32'h0,  32'h5, Y, N, 32'h00A00093, 32'h11111111, N, N};
        vecs[12] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, N, 32'h0,  32'h5, N, N, 32'h00A00093, 32'h11111111, N, N};
        vecs[13] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, Y, 32'h00000BAD,   N, N, 32'h0,  32'h5, N, N, 32'h00A00093, 32'h11111111, N, N};
        vecs[14] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, N, 32'h0,  32'h5, N, N, 32'h00A00093, 32'h11111111, N, Y};
        vecs[15] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, N, 32'h0,  32'h5, N, N, 32'h00A00093, 32'h11111111, N, Y};
        vecs[16] = '{N, N, 32'h0, N, Y, N, 32'h30, 32'h0, N, 32'h0,          N, N, 32'h0,  32'h5, N, N, 32'h00A00093, 32'h11111111, Y, Y};
        vecs[17] = '{Y, N, 32'h0, N, Y, N, 32'h30, 32'h0, N, 32'h0,          Y, N, 32'h30, 32'h0, N, N, 32'h00A00093, 32'h11111111, Y, Y};
        vecs[18] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, Y, 32'h0000CAFE,   N, N, 32'h0,  32'h0, N, N, 32'h0,        32'h0,        N, N};
        vecs[19] = '{N, N, 32'h0, N, N, N, 32'h0,  32'h0, N, 32'h0,          N, N, 32'h0,  32'h0, N, N, 32'h0,        32'h0,        N, Y};

        idle_inputs();
        do_reset();
        #1;
        check_output("reset mem_req", 32'(mem_req), 32'd0);
        check_output("reset mem_addr", mem_addr, 32'd0);
        check_output("reset i_ready", 32'(i_ready), 32'd0);
        check_output("reset d_ready", 32'(d_ready), 32'd0);
        check_output("reset err", 32'(err), 32'd0);
        check_output("reset stall", 32'(stall), 32'd0);

        for (int r = 0; r < NVEC; r++) begin
            @(negedge clk);
            apply_stimulus(vecs[r]);
            #1;
            check_output($sformatf("row%0d mem_req", r),   32'(mem_req), 32'(vecs[r].e_mem_req));
            check_output($sformatf("row%0d mem_we", r),    32'(mem_we),  32'(vecs[r].e_mem_we));
            check_output($sformatf("row%0d mem_addr", r),  mem_addr,     vecs[r].e_mem_addr);
            check_output($sformatf("row%0d mem_wdata", r), mem_wdata,    vecs[r].e_mem_wdata);
            check_output($sformatf("row%0d i_ready", r),   32'(i_ready), 32'(vecs[r].e_i_ready));
            check_output($sformatf("row%0d d_ready", r),   32'(d_ready), 32'(vecs[r].e_d_ready));
            check_output($sformatf("row%0d i_rdata", r),   i_rdata,      vecs[r].e_i_rdata);
            check_output($sformatf("row%0d d_rdata", r),   d_rdata,      vecs[r].e_d_rdata);
            check_output($sformatf("row%0d stall", r),     32'(stall),   32'(vecs[r].e_stall));
            check_output($sformatf("row%0d err", r),       32'(err),     32'(vecs[r].e_err));
        end

        // Starvation guard: both requesters held, every transaction acked at once.
        do_reset();
        exp_order = '{1, 1, 1, 1, 0, 1};
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_addr = 32'h200; d_we = 0;
        ngrants = 0;
        for (int c = 0; c < 200 && ngrants < 6; c++) begin
            @(negedge clk);
            if (mem_req) begin
                owners[ngrants] = (mem_addr == 32'h200);
                ngrants++;
                mem_ack = 1;
                mem_rdata = 32'(c);
            end else begin
                mem_ack = 0;
            end
        end
        @(negedge clk);
        mem_ack = 0;
        check_output("streak grant count", 32'(ngrants), 32'd6);
        for (int g = 0; g < 6; g++)
            check_output($sformatf("streak grant%0d is_d", g), 32'(owners[g]), 32'(exp_order[g]));
        check_output("streak err", 32'(err), 32'd0);
        idle_inputs();

        // Flush during BUSY_I squashes the result; the following fetch is unaffected.
        do_reset();
        do_fetch("pre fetch", 32'h4, 32'h12345678);
        @(negedge clk);
        i_req = 1; i_addr = 32'h8;
        @(negedge clk);
        check_output("flush grant mem_req", 32'(mem_req), 32'd1);
        check_output("flush grant mem_addr", mem_addr, 32'h8);
        i_flush = 1;
        @(negedge clk);
        i_flush = 0;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ack = 0;
        #1;
        check_output("flush i_ready", 32'(i_ready), 32'd0);
        check_output("flush i_rdata", i_rdata, 32'h12345678);
        check_output("flush mem_req", 32'(mem_req), 32'd0);
        check_output("flush stall", 32'(stall), 32'd1);
        do_fetch("post flush", 32'h40, 32'h0BADF00D);
        check_output("flush err", 32'(err), 32'd0);

        // Flush in the completion cycle hides that cycle's ready pulse.
        @(negedge clk);
        @(negedge clk);
        i_req = 1; i_addr = 32'h50;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (mem_req) found = 1;
        end
        check_output("done flush grant timeout", 32'(found), 32'd1);
        mem_ack = 1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_ack = 0;
        i_flush = 1;
        #1;
        check_output("done flush i_ready", 32'(i_ready), 32'd0);
        i_req = 0;
        @(negedge clk);
        i_flush = 0;
        #1;
        check_output("done flush i_ready after", 32'(i_ready), 32'd0);
        check_output("done flush err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing memory port between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Serialises the requests with a registered FSM and returns registered read data.
- Drives a stall that freezes the PC, IF/ID and later pipeline registers while a requester waits.
- Honours branch/jump flush by discarding an in-flight fetch.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits before a fetch is forced (range 1..15)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
i_req_i  in  1  fetch request, held until i_ready_o
i_addr_i  in  ADDR_W  fetch address (PC)
i_flush_i  in  1  branch/jump flush; cancels the pending fetch
i_rdata_o  out  DATA_W  fetched instruction, valid with i_ready_o
i_ready_o  out  1  one-cycle fetch completion pulse
d_req_i  in  1  data request, held until d_ready_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_W  data address (EX/MEM ALU result)
d_wdata_i  in  DATA_W  store data
d_rdata_o  out  DATA_W  load data, valid with d_ready_o
d_ready_o  out  1  one-cycle data completion pulse
mem_req_o  out  1  backing memory request, held until mem_ack_i
mem_we_o  out  1  backing write enable
mem_addr_o  out  ADDR_W  backing address
mem_wdata_o  out  DATA_W  backing write data
mem_ack_i  in  1  one-cycle completion from backing memory; rdata valid with it
mem_rdata_i  in  DATA_W  backing read data
stall_o  out  1  (i_req_i & ~i_ready_o) | (d_req_i & ~d_ready_o), combinational
err_o  out  1  sticky protocol error flag

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE. All outputs are registered except stall_o.
- Reset (rst_i=1 at an edge): state IDLE. All of these clear to 0: mem_* outputs, i_ready_o, d_ready_o, i_rdata_o, d_rdata_o, err_o, streak counter, squash flag, owner flag.
- IDLE, grant rule:
  - If d_req_i=1 and (i_req_i=0 or streak<MAX_D_STREAK): grant D and streak++ (only when i_req_i=1).
  - Else if i_req_i=1 and i_flush_i=0: grant I and streak=0.
  - The fetch request is masked while i_flush_i=1.
- On grant, latch addr/we/wdata into mem_* and set mem_req_o=1 next cycle. Go to BUSY_I or BUSY_D. mem_we_o=0 for fetches.
- BUSY_x:
  - mem_* held stable until mem_ack_i=1.
  - On ack: mem_req_o←0, capture mem_rdata_i into the owner's rdata register, pulse the owner's ready next cycle, go to DONE.
- DONE: the ready pulse is high for exactly this one cycle. No grant is made in DONE. Go to IDLE next cycle.
- Minimum turnaround:
  - req seen in IDLE at cycle 0; mem_req_o high at cycle 1.
  - If ack at cycle 1, ready at cycle 2; next grant at cycle 3.
- Stores: d_rdata_o is updated with mem_rdata_i and its value is don't-care; d_ready_o still pulses.
- Flush:
  - i_flush_i=1 while in BUSY_I sets the squash flag. The memory transaction completes normally, but i_ready_o stays 0 and i_rdata_o is not updated. squash clears on entry to DONE.
  - Flush in DONE with owner I suppresses that cycle's i_ready_o.
  - Flush has no effect on D transactions.
- Simultaneous d_req_i and i_req_i rising with streak at MAX_D_STREAK: I wins and streak resets to 0.
- d_req_i deasserted while i_req_i=1: streak resets to 0.
- Streak counter saturates at MAX_D_STREAK.
- err_o is set (sticky until reset) on:
  - mem_ack_i=1 in IDLE or DONE;
  - d_req_i or i_req_i dropping while the owner is BUSY.
  The FSM otherwise ignores the spurious ack.
- rst_i mid-transaction: immediate return to IDLE. mem_req_o=0 the next cycle. A pending ack is not reported.

Test Plan:
- Single load: d_req_i=1, d_addr_i=0x10, ack after 2 cycles with rdata 0xDEADBEEF -> mem_req_o high cycles 1-3, d_ready_o=1 at cycle 4 with d_rdata_o=0xDEADBEEF, stall_o=1 cycles 0-3.
- Simultaneous requests, I addr 0x0 and D store addr 0x20 data 0x5 -> D granted first (mem_we_o=1, mem_wdata_o=0x5); I is granted at DONE+1 and returns its instruction.
- Starvation guard, MAX_D_STREAK=4: d_req_i held continuously with i_req_i=1 -> grant order D,D,D,D,I,D...
- Flush mid-fetch: I granted at addr 0x8, i_flush_i pulse during BUSY_I, ack 3 cycles later -> i_ready_o never asserts and i_rdata_o is unchanged. Next fetch at 0x40 completes normally.
- Protocol error: mem_ack_i pulse in IDLE -> err_o=1 from the next cycle and stays high; no ready pulse; state remains IDLE.
- Reset mid-BUSY_D: rst_i=1 for one cycle -> mem_req_o=0, all ready outputs 0, err_o=0, state IDLE; a later ack sets err_o=1.
